jk_bank_arbiter: RTL and testbench

- Owns a bank of NBITS JK flip-flop cells and shares write access to it between NREQ requesters.
- Each requester posts one JK command (hold/reset/set/toggle) against one cell address.
- A round-robin arbiter grants one command per slot and the block applies it to the addressed cell.
- Sits between software/control requesters and the JK state bank; bank state is exported as a flat vector.

---
 rtl/jk_bank_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_jk_bank_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter that applies JK commands from NREQ requesters to a bank of NBITS JK cells.
// Optional build macro JK_ARB_PRIO0_EN makes requester 0 a fixed-priority lane outside the rotation.
module jk_bank_arbiter #(
   parameter int NREQ  = 4,
   parameter int NBITS = 6,
   parameter int AW    = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*2-1:0]    req_jk,
   output logic [NREQ-1:0]      gnt,
   output logic                 busy,
   output logic [NBITS-1:0]     q,
   output logic                 done,
   output logic                 done_q,
   output logic                 err
);

   localparam int              IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [AW:0]     NBITS_W  = (AW+1)'(NBITS);
   localparam logic [IW:0]     NREQ_W   = (IW+1)'(NREQ);
   localparam logic [IW-1:0]   LAST_W   = IW'(NREQ-1);
   localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_APPLY = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t           state_r, state_s;
   logic [IW-1:0]    rr_ptr_r, rr_ptr_s;
   logic [AW-1:0]    cmd_addr_r, cmd_addr_s;
   logic [1:0]       cmd_jk_r, cmd_jk_s;
   logic [NBITS-1:0] q_r, q_s, q_upd_s;
   logic [NREQ-1:0]  gnt_r, gnt_s;
   logic             busy_r;
   logic             done_r, done_s;
   logic             done_q_r, done_q_s;
   logic             err_r, err_s;
   logic             found_s;
   logic [IW-1:0]    pick_s, ptr_adv_s;
   logic [IW:0]      cand_s;
   logic             keep_ptr_s;
   logic             in_range_s;
   logic             new_bit_s;

   function automatic logic jk_next(input logic cur, input logic [1:0] jk);
      logic nxt;
      case (jk)
         2'b00:   nxt = cur;
         2'b01:   nxt = 1'b0;
         2'b10:   nxt = 1'b1;
         2'b11:   nxt = ~cur;
         default: nxt = cur;
      endcase
      return nxt;
   endfunction

   // Winner search: first requester at or after rr_ptr, wrapping modulo NREQ
   always_comb begin
      found_s    = 1'b0;
      pick_s     = '0;
      cand_s     = '0;
      keep_ptr_s = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         cand_s = {1'b0, rr_ptr_r} + (IW+1)'(i);
         if (cand_s >= NREQ_W) begin
            cand_s = cand_s - NREQ_W;
         end else begin
            cand_s = cand_s;
         end
         if (!found_s && req[cand_s[IW-1:0]]) begin
            found_s = 1'b1;
            pick_s  = cand_s[IW-1:0];
         end else begin
            found_s = found_s;
         end
      end
`ifdef JK_ARB_PRIO0_EN
      // requester 0 bypasses the rotation and leaves rr_ptr where it was
      if (req[0]) begin
         found_s    = 1'b1;
         pick_s     = '0;
         keep_ptr_s = 1'b1;
      end else begin
         keep_ptr_s = 1'b0;
      end
`endif
   end

   // Pointer value following a grant to pick_s
   always_comb begin
      if (pick_s == LAST_W) begin
         ptr_adv_s = '0;
      end else begin
         ptr_adv_s = pick_s + IW'(1'b1);
      end
   end

   // Bank image with the latched command applied; out-of-range addresses touch nothing
   always_comb begin
      in_range_s = ({1'b0, cmd_addr_r} < NBITS_W);
      q_upd_s    = q_r;
      new_bit_s  = 1'b0;
      for (int n = 0; n < NBITS; n++) begin
         if (in_range_s && (cmd_addr_r == AW'(n))) begin
            q_upd_s[n] = jk_next(q_r[n], cmd_jk_r);
            new_bit_s  = q_upd_s[n];
         end else begin
            q_upd_s[n] = q_r[n];
         end
      end
   end

   // FSM next state and next values of all registered outputs
   always_comb begin
      state_s    = state_r;
      rr_ptr_s   = rr_ptr_r;
      cmd_addr_s = cmd_addr_r;
      cmd_jk_s   = cmd_jk_r;
      q_s        = q_r;
      gnt_s      = '0;
      done_s     = 1'b0;
      done_q_s   = 1'b0;
      err_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (found_s) begin
               state_s    = ST_APPLY;
               gnt_s      = ONE_HOT0 << pick_s;
               cmd_addr_s = req_addr[int'(pick_s)*AW +: AW];
               cmd_jk_s   = req_jk[int'(pick_s)*2 +: 2];
               rr_ptr_s   = keep_ptr_s ? rr_ptr_r : ptr_adv_s;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_APPLY: begin
            state_s  = ST_DONE;
            q_s      = q_upd_s;
            done_s   = 1'b1;
            done_q_s = new_bit_s;
            err_s    = ~in_range_s;
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, command latch, bank and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         rr_ptr_r   <= '0;
         cmd_addr_r <= '0;
         cmd_jk_r   <= 2'b00;
         q_r        <= '0;
         gnt_r      <= '0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         done_q_r   <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         state_r    <= state_s;
         rr_ptr_r   <= rr_ptr_s;
         cmd_addr_r <= cmd_addr_s;
         cmd_jk_r   <= cmd_jk_s;
         q_r        <= q_s;
         gnt_r      <= gnt_s;
         busy_r     <= (state_s != ST_IDLE);
         done_r     <= done_s;
         done_q_r   <= done_q_s;
         err_r      <= err_s;
      end
   end

   assign gnt    = gnt_r;
   assign busy   = busy_r;
   assign q      = q_r;
   assign done   = done_r;
   assign done_q = done_q_r;
   assign err    = err_r;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Self-checking bench for jk_bank_arbiter: directed vector table, fairness and reset
// sequences, and randomized request sets checked against a transaction-level model.
module tb_jk_bank_arbiter;

   localparam int NREQ  = 4;
   localparam int NBITS = 6;
   localparam int AW    = 3;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [NREQ-1:0]     req = '0;
   logic [NREQ*AW-1:0]  req_addr = '0;
   logic [NREQ*2-1:0]   req_jk = '0;
   logic [NREQ-1:0]     gnt;
   logic                busy;
   logic [NBITS-1:0]    q;
   logic                done;
   logic                done_q;
   logic                err;

   int total = 0;
   int bad   = 0;

   // model state: bank contents and rotation pointer
   logic [NBITS-1:0] mq = '0;
   int               mptr = 0;

   logic [AW-1:0]    a_tab[NREQ];
   logic [1:0]       j_tab[NREQ];
   logic [NREQ-1:0]  gq[$];
   logic             last_dq;
   logic             last_err;

   typedef struct {
      int              rq;
      logic [AW-1:0]   addr;
      logic [1:0]      jk;
      logic [NBITS-1:0] exp_q;
      logic            exp_dq;
      logic            exp_err;
   } vec_t;

   vec_t vecs[15];

   jk_bank_arbiter #(.NREQ(NREQ), .NBITS(NBITS), .AW(AW)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_addr (req_addr),
      .req_jk   (req_jk),
      .gnt      (gnt),
      .busy     (busy),
      .q        (q),
      .done     (done),
      .done_q   (done_q),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic drive_cmds();
      for (int i = 0; i < NREQ; i++) begin
         req_addr[i*AW +: AW] = a_tab[i];
         req_jk[i*2 +: 2]     = j_tab[i];
      end
   endtask

   task automatic randomize_cmds();
      for (int i = 0; i < NREQ; i++) begin
         a_tab[i] = AW'($urandom_range(0, 7));
         j_tab[i] = 2'($urandom_range(0, 3));
      end
   endtask

   // JK rule applied to the model bank
   task automatic model_cmd(input logic [AW-1:0] a, input logic [1:0] jk,
                            output logic dq, output logic e);
      if (int'(a) >= NBITS) begin
         e  = 1'b1;
         dq = 1'b0;
      end else begin
         case (jk)
            2'b01:   mq[a] = 1'b0;
            2'b10:   mq[a] = 1'b1;
            2'b11:   mq[a] = ~mq[a];
            default: mq[a] = mq[a];
         endcase
         e  = 1'b0;
         dq = mq[a];
      end
   endtask

   function automatic int model_pick(input logic [NREQ-1:0] p);
`ifdef JK_ARB_PRIO0_EN
      if (p[0]) return 0;
`endif
      for (int k = 0; k < NREQ; k++) begin
         if (p[(mptr + k) % NREQ]) return (mptr + k) % NREQ;
      end
      return 0;
   endfunction

   task automatic model_advance(input int w);
`ifdef JK_ARB_PRIO0_EN
      if (w == 0) return;
`endif
      mptr = (w + 1) % NREQ;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      tick();
      tick();
      rst  = 1'b0;
      mq   = '0;
      mptr = 0;
   endtask

   // Hold all requesters in mask; each drops its request in the cycle after its grant
   task automatic serve(input logic [NREQ-1:0] mask);
      logic [NREQ-1:0] pending;
      int   w;
      int   n;
      int   lim;
      logic dq;
      logic e;
      bit   first;
      pending = mask;
      drive_cmds();
      req   = pending;
      first = 1'b1;
      while (pending != '0) begin
         w   = model_pick(pending);
         lim = first ? 1 : 2;
         tick();
         n = 1;
         while (gnt == '0 && n < 8) begin
            tick();
            n++;
         end
         chk("gnt", 32'(gnt), 32'(1) << w);
         chk("gnt_latency", 32'(n), 32'(lim));
         chk("busy_apply", 32'(busy), 32'd1);
         gq.push_back(gnt);
         model_cmd(a_tab[w], j_tab[w], dq, e);
         model_advance(w);
         tick();
         chk("done", 32'(done), 32'd1);
         chk("done_q", 32'(done_q), 32'(dq));
         chk("err", 32'(err), 32'(e));
         chk("q", 32'(q), 32'(mq));
         chk("gnt_pulse", 32'(gnt), 32'd0);
         last_dq  = done_q;
         last_err = err;
         pending[w] = 1'b0;
         req   = pending;
         first = 1'b0;
      end
      tick();
      chk("busy_idle", 32'(busy), 32'd0);
      chk("done_pulse", 32'(done), 32'd0);
   endtask

   initial begin
      logic [NREQ-1:0] m;
      logic [NREQ-1:0] order[4];

      vecs[0]  = '{2, 3'd3, 2'b10, 6'b001000, 1'b1, 1'b0};
      vecs[1]  = '{1, 3'd0, 2'b11, 6'b001001, 1'b1, 1'b0};
      vecs[2]  = '{1, 3'd0, 2'b11, 6'b001000, 1'b0, 1'b0};
      vecs[3]  = '{3, 3'd7, 2'b10, 6'b001000, 1'b0, 1'b1};
      vecs[4]  = '{0, 3'd0, 2'b10, 6'b001001, 1'b1, 1'b0};
      vecs[5]  = '{0, 3'd1, 2'b10, 6'b001011, 1'b1, 1'b0};
      vecs[6]  = '{2, 3'd2, 2'b10, 6'b001111, 1'b1, 1'b0};
      vecs[7]  = '{3, 3'd4, 2'b10, 6'b011111, 1'b1, 1'b0};
      vecs[8]  = '{1, 3'd5, 2'b10, 6'b111111, 1'b1, 1'b0};
      vecs[9]  = '{2, 3'd3, 2'b11, 6'b110111, 1'b0, 1'b0};
      vecs[10] = '{2, 3'd3, 2'b11, 6'b111111, 1'b1, 1'b0};
      vecs[11] = '{0, 3'd4, 2'b00, 6'b111111, 1'b1, 1'b0};
      vecs[12] = '{3, 3'd4, 2'b01, 6'b101111, 1'b0, 1'b0};
      vecs[13] = '{1, 3'd6, 2'b11, 6'b101111, 1'b0, 1'b1};
      vecs[14] = '{0, 3'd5, 2'b01, 6'b001111, 1'b0, 1'b0};

      // reset state
      tick();
      tick();
      chk("rst_q", 32'(q), 32'd0);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_done_q", 32'(done_q), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      rst = 1'b0;
      tick();
      chk("idle_gnt", 32'(gnt), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);

      // directed vector table, one requester per command
      for (int v = 0; v < 15; v++) begin
         randomize_cmds();
         a_tab[vecs[v].rq] = vecs[v].addr;
         j_tab[vecs[v].rq] = vecs[v].jk;
         m = '0;
         m[vecs[v].rq] = 1'b1;
         serve(m);
         chk("tab_q", 32'(q), 32'(vecs[v].exp_q));
         chk("tab_done_q", 32'(last_dq), 32'(vecs[v].exp_dq));
         chk("tab_err", 32'(last_err), 32'(vecs[v].exp_err));
      end

      // fairness: all four requesting at once from rr_ptr=0
      do_reset();
      randomize_cmds();
      gq.delete();
      serve(4'b1111);
      order[0] = 4'b0001;
      order[1] = 4'b0010;
      order[2] = 4'b0100;
      order[3] = 4'b1000;
      chk("fair_count", 32'(gq.size()), 32'd4);
      for (int k = 0; k < 4 && k < gq.size(); k++) begin
         chk("fair_order", 32'(gq[k]), 32'(order[k]));
      end

      // reset in the middle of a command
      do_reset();
      randomize_cmds();
      a_tab[1] = 3'd2;
      j_tab[1] = 2'b10;
      serve(4'b0010);
      a_tab[2] = 3'd5;
      j_tab[2] = 2'b10;
      drive_cmds();
      req = 4'b0100;
      tick();
      chk("mid_gnt", 32'(gnt), 32'h4);
      rst = 1'b1;
      #1;
      chk("mid_rst_q", 32'(q), 32'd0);
      chk("mid_rst_gnt", 32'(gnt), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      req = '0;
      tick();
      tick();
      rst  = 1'b0;
      mq   = '0;
      mptr = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("post_rst_done", 32'(done), 32'd0);
         chk("post_rst_err", 32'(err), 32'd0);
         chk("post_rst_gnt", 32'(gnt), 32'd0);
         chk("post_rst_q", 32'(q), 32'd0);
      end
      // rr_ptr back at 0: requester 1 must beat requester 3
      randomize_cmds();
      gq.delete();
      serve(4'b1010);
      chk("post_rst_first", 32'(gq.size() > 0 ? gq[0] : 4'b0000), 32'h2);

      // randomized request sets against the model
      do_reset();
      for (int it = 0; it < 60; it++) begin
         randomize_cmds();
         m = NREQ'($urandom_range(1, 15));
         serve(m);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
